// File: rtl/bar_height_scheduler.sv
// bar_height_scheduler: per-frame controller for the spectrum-to-bar datapath.
// Each frame it reads one audio bin per bar over a request/valid port, applies
// instant-attack / linear-decay smoothing, tracks the tallest bar and drives
// registered heights to the bar renderer.
// Optional build macro: BAR_SHADOW_COMMIT_EN -- heights are accumulated in a
// shadow array and committed to bar_height in one edge at frame completion.
module bar_height_scheduler #(
   parameter int BAR_COUNT  = 32,
   parameter int HEIGHT_W   = 10,
   parameter int BIN_W      = 32,
   parameter int BIN_LSB    = 22,
   parameter int BIN_MSB    = 27,
   parameter int HEIGHT_MAX = 479,
   parameter int DECAY_STEP = 2,
   localparam int ADDR_W    = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1
) (
   input  logic                          Reset,
   input  logic                          frame_clk,
   input  logic                          frame_req,
   output logic                          bin_rd,
   output logic [ADDR_W-1:0]             bin_addr,
   input  logic                          bin_rvalid,
   input  logic [BIN_W-1:0]              bin_data,
   output logic [BAR_COUNT*HEIGHT_W-1:0] bar_height,
   output logic [ADDR_W-1:0]             max_idx,
   output logic [HEIGHT_W-1:0]           max_height,
   output logic                          busy,
   output logic                          done
);

   localparam int                  FIELD_W  = BIN_MSB - BIN_LSB + 1;
   localparam logic [ADDR_W-1:0]   LAST_IDX = ADDR_W'(BAR_COUNT - 1);
   localparam logic [HEIGHT_W-1:0] H_MAX    = HEIGHT_W'(HEIGHT_MAX);
   localparam logic [HEIGHT_W-1:0] H_DECAY  = HEIGHT_W'(DECAY_STEP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_W-1:0]     idx_q;
   logic                  pending_q;
   logic [ADDR_W-1:0]     run_idx_q;
   logic [HEIGHT_W-1:0]   run_h_q;
   logic [ADDR_W-1:0]     max_idx_q;
   logic [HEIGHT_W-1:0]   max_h_q;
   logic [HEIGHT_W-1:0]   vis_q [BAR_COUNT];
`ifdef BAR_SHADOW_COMMIT_EN
   logic [HEIGHT_W-1:0]   shadow_q [BAR_COUNT];
`endif

   logic [FIELD_W-1:0]    field;
   logic [HEIGHT_W-1:0]   raw_ext;
   logic [HEIGHT_W-1:0]   raw_h;
   logic [HEIGHT_W-1:0]   old_h;
   logic [HEIGHT_W-1:0]   decayed_h;
   logic [HEIGHT_W-1:0]   new_h;
   logic [ADDR_W-1:0]     nxt_run_idx;
   logic [HEIGHT_W-1:0]   nxt_run_h;
   logic                  start;
   logic                  accept;
   logic                  last_bar;
   logic                  unused_bin_bits;

   // Bits of the bin word outside the magnitude field carry no height information.
   assign unused_bin_bits = ^bin_data;

   assign start    = (state_q == IDLE) && (frame_req || pending_q);
   assign accept   = (state_q == WAIT) && bin_rvalid;
   assign last_bar = (idx_q == LAST_IDX);

   assign bin_rd     = (state_q == REQ);
   assign bin_addr   = idx_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign max_idx    = max_idx_q;
   assign max_height = max_h_q;

   // Smoothing datapath: extract, clamp, then instant attack or bounded decay.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      field       = bin_data[BIN_MSB:BIN_LSB];
      raw_ext     = HEIGHT_W'(field);
      raw_h       = (raw_ext > H_MAX) ? H_MAX : raw_ext;
`ifdef BAR_SHADOW_COMMIT_EN
      old_h       = shadow_q[idx_q];
`else
      old_h       = vis_q[idx_q];
`endif
      decayed_h   = (old_h > H_DECAY) ? (old_h - H_DECAY) : '0;
      new_h       = raw_h;
      if (raw_h < old_h) begin
         new_h = (decayed_h > raw_h) ? decayed_h : raw_h;
      end
      // Strict compare: on a tie the earlier (lower) index keeps the max.
      nxt_run_idx = run_idx_q;
      nxt_run_h   = run_h_q;
      if (new_h > run_h_q) begin
         nxt_run_idx = idx_q;
         nxt_run_h   = new_h;
      end
   end

   // FSM state register.
   always_ff @(posedge frame_clk or posedge Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state: one read per bar, stall in WAIT until the bin arrives.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = REQ;
         REQ:  state_d = WAIT;
         WAIT: if (bin_rvalid) state_d = last_bar ? DONE : REQ;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bar index, request merging, running maximum and the published maximum.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         idx_q     <= '0;
         pending_q <= 1'b0;
         run_idx_q <= '0;
         run_h_q   <= '0;
         max_idx_q <= '0;
         max_h_q   <= '0;
      end else begin
         if (start)                              pending_q <= 1'b0;
         else if (frame_req && state_q != IDLE)  pending_q <= 1'b1;

         if (start) begin
            idx_q     <= '0;
            run_idx_q <= '0;
            run_h_q   <= '0;
         end else if (accept) begin
            run_idx_q <= nxt_run_idx;
            run_h_q   <= nxt_run_h;
            if (last_bar) begin
               max_idx_q <= nxt_run_idx;
               max_h_q   <= nxt_run_h;
            end else begin
               idx_q <= idx_q + ADDR_W'(1);
            end
         end
      end
   end

   // Height storage: in-place update, or shadow accumulate with a commit at frame end.
   always_ff @(posedge frame_clk or posedge Reset) begin
      // NOTE: the height bank is a register array, not a RAM, so it is cleared by Reset like any other state.
      if (Reset) begin
         for (int j = 0; j < BAR_COUNT; j++) begin
            vis_q[j] <= '0;
`ifdef BAR_SHADOW_COMMIT_EN
            shadow_q[j] <= '0;
`endif
         end
      end else if (accept) begin
`ifdef BAR_SHADOW_COMMIT_EN
         shadow_q[idx_q] <= new_h;
         if (last_bar) begin
            for (int j = 0; j < BAR_COUNT; j++) begin
               vis_q[j] <= (ADDR_W'(j) == idx_q) ? new_h : shadow_q[j];
            end
         end
`else
         vis_q[idx_q] <= new_h;
`endif
      end
   end

   // Flatten the visible heights onto the renderer bus.
   always_comb begin
      bar_height = '0;
      for (int j = 0; j < BAR_COUNT; j++) begin
         bar_height[j*HEIGHT_W +: HEIGHT_W] = vis_q[j];
      end
   end

endmodule

// File: tb/tb_bar_height_scheduler.sv
// tb_bar_height_scheduler: directed bench for bar_height_scheduler with a
// request/valid bin memory model of programmable latency.
module tb_bar_height_scheduler;

   localparam int BC = 32;
   localparam int HW = 10;
   localparam int AW = 5;

   logic               Reset;
   logic               frame_clk;
   logic               frame_req;
   logic               bin_rd;
   logic [AW-1:0]      bin_addr;
   logic               bin_rvalid;
   logic [31:0]        bin_data;
   logic [BC*HW-1:0]   bar_height;
   logic [AW-1:0]      max_idx;
   logic [HW-1:0]      max_height;
   logic               busy;
   logic               done;

   bar_height_scheduler #(
      .BAR_COUNT(BC), .HEIGHT_W(HW), .BIN_W(32), .BIN_LSB(22), .BIN_MSB(27),
      .HEIGHT_MAX(479), .DECAY_STEP(2)
   ) dut (
      .Reset(Reset), .frame_clk(frame_clk), .frame_req(frame_req),
      .bin_rd(bin_rd), .bin_addr(bin_addr), .bin_rvalid(bin_rvalid), .bin_data(bin_data),
      .bar_height(bar_height), .max_idx(max_idx), .max_height(max_height),
      .busy(busy), .done(done)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [5:0]    mag [BC];
   logic [HW-1:0] exp_bar [BC];
   int            lat = 1;

   int            cyc = 0;
   int            t0 = 0;
   int            rd_cnt = 0;
   int            done_cnt = 0;
   int            double_rd = 0;
   int            shadow_viol = 0;
   int            rd_addr [256];
   int            rd_cyc [256];
   int            done_cyc [8];
   logic [AW-1:0] done_max_idx;
   logic [HW-1:0] done_max_h;
   logic [BC*HW-1:0] snap20;
   logic [BC*HW-1:0] prev_bars;
   logic          prev_rd = 1'b0;

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   initial forever begin
      @(posedge frame_clk);
      cyc = cyc + 1;
   end

   // Bin memory: bin_rvalid is high in the cycle lat cycles after the bin_rd cycle.
   initial begin
      int a;
      bin_rvalid = 1'b0;
      bin_data   = '0;
      forever begin
         @(negedge frame_clk);
         if (bin_rd === 1'b1) begin
            a = int'(bin_addr);
            repeat (lat) @(posedge frame_clk);
            #1;
            bin_rvalid = 1'b1;
            bin_data   = {4'hA, mag[a], 22'h15A5A5};
            @(posedge frame_clk);
            #1;
            bin_rvalid = 1'b0;
            bin_data   = 32'hFFFF_FFFF;
         end
      end
   end

   // Monitor sampled mid-cycle; cycle numbers are relative to the frame_req cycle.
   initial begin
      prev_bars = '0;
      forever begin
         @(negedge frame_clk);
         if (bin_rd === 1'b1) begin
            if (rd_cnt < 256) begin
               rd_addr[rd_cnt] = int'(bin_addr);
               rd_cyc[rd_cnt]  = cyc - t0;
            end
            rd_cnt = rd_cnt + 1;
            if (prev_rd) double_rd = double_rd + 1;
         end
         prev_rd = (bin_rd === 1'b1);
         if (done === 1'b1) begin
            if (done_cnt < 8) done_cyc[done_cnt] = cyc - t0;
            done_cnt     = done_cnt + 1;
            done_max_idx = max_idx;
            done_max_h   = max_height;
         end
         if (cyc - t0 == 20) snap20 = bar_height;
`ifdef BAR_SHADOW_COMMIT_EN
         if (done !== 1'b1 && Reset !== 1'b1 && bar_height !== prev_bars) shadow_viol = shadow_viol + 1;
`endif
         prev_bars = bar_height;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [HW-1:0] get_bar(input int i);
      return bar_height[i*HW +: HW];
   endfunction

   task automatic start_frame();
      @(negedge frame_clk);
      rd_cnt    = 0;
      done_cnt  = 0;
      double_rd = 0;
      t0        = cyc;
      frame_req = 1'b1;
      @(negedge frame_clk);
      frame_req = 1'b0;
   endtask

   task automatic pulse_req();
      @(negedge frame_clk);
      frame_req = 1'b1;
      @(negedge frame_clk);
      frame_req = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         @(negedge frame_clk);
         k++;
      end
      n_cmp++;
      if (done_cnt < target) begin
         n_err++;
         $display("FAIL %s: saw %0d done pulses, required %0d within %0d cycles", name, done_cnt, target, budget);
      end
      @(negedge frame_clk);
   endtask

   task automatic do_reset();
      @(negedge frame_clk);
      Reset = 1'b1;
      repeat (2) @(negedge frame_clk);
      Reset = 1'b0;
   endtask

   task automatic run_frame(input string name);
      start_frame();
      wait_done(1, 400, name);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge frame_clk);
      n_cmp++;
      if (bin_rd !== 1'b0) begin n_err++; $display("FAIL reset_bin_rd: got %b required 0", bin_rd); end
      Reset = 1'b0;
      repeat (20) @(negedge frame_clk);
      n_cmp++;
      if (bar_height !== '0) begin n_err++; $display("FAIL reset_heights: got %h required 0", bar_height); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_cmp++;
      if (done_cnt !== 0) begin n_err++; $display("FAIL reset_done: got %0d pulses required 0", done_cnt); end
      n_cmp++;
      if (rd_cnt !== 0) begin n_err++; $display("FAIL reset_rd: got %0d reads required 0", rd_cnt); end
      n_cmp++;
      if (max_idx !== '0 || max_height !== '0) begin
         n_err++; $display("FAIL reset_max: got %0d/%0d required 0/0", max_idx, max_height);
      end
      n_cmp++;
      if (bin_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0d required 0", bin_addr); end
   endtask

   task automatic test_ramp();
      for (int i = 0; i < BC; i++) begin
         mag[i]     = 6'(i);
         exp_bar[i] = HW'(i);
      end
      run_frame("ramp_done");
      n_cmp++;
      if (rd_cnt !== 32) begin n_err++; $display("FAIL ramp_rd_cnt: got %0d required 32", rd_cnt); end
      for (int k = 0; k < 32; k++) begin
         n_cmp++;
         if (rd_addr[k] !== k || rd_cyc[k] !== 2*k+1) begin
            n_err++;
            $display("FAIL ramp_rd[%0d]: got addr %0d cycle %0d required addr %0d cycle %0d", k, rd_addr[k], rd_cyc[k], k, 2*k+1);
         end
      end
      n_cmp++;
      if (done_cyc[0] !== 65) begin n_err++; $display("FAIL ramp_done_cycle: got %0d required 65", done_cyc[0]); end
      n_cmp++;
      if (double_rd !== 0) begin n_err++; $display("FAIL ramp_rd_width: got %0d multi-cycle strobes required 0", double_rd); end
      n_cmp++;
      if (done_max_idx !== 5'd31 || done_max_h !== 10'd31) begin
         n_err++; $display("FAIL ramp_max_at_done: got %0d/%0d required 31/31", done_max_idx, done_max_h);
      end
      for (int i = 0; i < BC; i++) begin
         n_cmp++;
         if (get_bar(i) !== exp_bar[i]) begin n_err++; $display("FAIL ramp_bar[%0d]: got %0d required %0d", i, get_bar(i), exp_bar[i]); end
      end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL ramp_idle: busy got %b required 0", busy); end
`ifdef BAR_SHADOW_COMMIT_EN
      n_cmp++;
      if (shadow_viol !== 0) begin n_err++; $display("FAIL shadow_stable: got %0d mid-frame changes required 0", shadow_viol); end
`endif
   endtask

   task automatic test_decay();
      logic [HW-1:0] exp_mid;
      mag[5] = 6'd40;
      run_frame("decay_f1");
`ifdef BAR_SHADOW_COMMIT_EN
      exp_mid = 10'd5;
`else
      exp_mid = 10'd40;
`endif
      n_cmp++;
      if (snap20[5*HW +: HW] !== exp_mid) begin n_err++; $display("FAIL decay_mid_frame: got %0d required %0d", snap20[5*HW +: HW], exp_mid); end
      n_cmp++;
      if (get_bar(5) !== 10'd40) begin n_err++; $display("FAIL decay_attack40: got %0d required 40", get_bar(5)); end
      mag[5] = 6'd10;
      run_frame("decay_f2");
      n_cmp++;
      if (get_bar(5) !== 10'd38) begin n_err++; $display("FAIL decay_first_step: got %0d required 38", get_bar(5)); end
      for (int f = 0; f < 13; f++) run_frame("decay_loop");
      n_cmp++;
      if (get_bar(5) !== 10'd12) begin n_err++; $display("FAIL decay_13_frames: got %0d required 12", get_bar(5)); end
      run_frame("decay_f16");
      n_cmp++;
      if (get_bar(5) !== 10'd10) begin n_err++; $display("FAIL decay_floor: got %0d required 10", get_bar(5)); end
      run_frame("decay_f17");
      n_cmp++;
      if (get_bar(5) !== 10'd10) begin n_err++; $display("FAIL decay_hold: got %0d required 10", get_bar(5)); end
      n_cmp++;
      if (get_bar(4) !== 10'd4 || get_bar(6) !== 10'd6) begin
         n_err++; $display("FAIL decay_neighbours: got %0d/%0d required 4/6", get_bar(4), get_bar(6));
      end
      mag[5] = 6'd63;
      run_frame("decay_attack");
      n_cmp++;
      if (get_bar(5) !== 10'd63) begin n_err++; $display("FAIL decay_attack63: got %0d required 63", get_bar(5)); end
      n_cmp++;
      if (max_idx !== 5'd5 || max_height !== 10'd63) begin
         n_err++; $display("FAIL decay_max: got %0d/%0d required 5/63", max_idx, max_height);
      end
   endtask

   task automatic test_ties();
      do_reset();
      for (int i = 0; i < BC; i++) begin
         mag[i]     = 6'd0;
         exp_bar[i] = '0;
      end
      mag[3] = 6'd50; mag[7] = 6'd50;
      exp_bar[3] = 10'd50; exp_bar[7] = 10'd50;
      run_frame("ties_done");
      n_cmp++;
      if (done_max_idx !== 5'd3 || done_max_h !== 10'd50) begin
         n_err++; $display("FAIL ties_max_at_done: got %0d/%0d required 3/50", done_max_idx, done_max_h);
      end
      n_cmp++;
      if (max_idx !== 5'd3 || max_height !== 10'd50) begin
         n_err++; $display("FAIL ties_max: got %0d/%0d required 3/50", max_idx, max_height);
      end
      for (int i = 0; i < BC; i++) begin
         n_cmp++;
         if (get_bar(i) !== exp_bar[i]) begin n_err++; $display("FAIL ties_bar[%0d]: got %0d required %0d", i, get_bar(i), exp_bar[i]); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int i = 0; i < BC; i++) begin
         mag[i]     = 6'(i);
         exp_bar[i] = HW'(i);
      end
      lat = 4;
      run_frame("stall_done");
      lat = 1;
      n_cmp++;
      if (done_cyc[0] !== 161) begin n_err++; $display("FAIL stall_done_cycle: got %0d required 161", done_cyc[0]); end
      n_cmp++;
      if (rd_cnt !== 32 || double_rd !== 0) begin
         n_err++; $display("FAIL stall_strobes: got %0d reads %0d long strobes required 32/0", rd_cnt, double_rd);
      end
      for (int k = 0; k < 32; k++) begin
         n_cmp++;
         if (rd_addr[k] !== k || rd_cyc[k] !== 5*k+1) begin
            n_err++;
            $display("FAIL stall_rd[%0d]: got addr %0d cycle %0d required addr %0d cycle %0d", k, rd_addr[k], rd_cyc[k], k, 5*k+1);
         end
      end
      for (int i = 0; i < BC; i++) begin
         n_cmp++;
         if (get_bar(i) !== exp_bar[i]) begin n_err++; $display("FAIL stall_bar[%0d]: got %0d required %0d", i, get_bar(i), exp_bar[i]); end
      end
      n_cmp++;
      if (max_idx !== 5'd31 || max_height !== 10'd31) begin
         n_err++; $display("FAIL stall_max: got %0d/%0d required 31/31", max_idx, max_height);
      end
   endtask

   task automatic test_pending();
      start_frame();
      repeat (8) @(negedge frame_clk);
      pulse_req();
      repeat (8) @(negedge frame_clk);
      pulse_req();
      wait_done(2, 400, "pending_done");
      repeat (20) @(negedge frame_clk);
      n_cmp++;
      if (done_cnt !== 2) begin n_err++; $display("FAIL pending_frames: got %0d done pulses required 2", done_cnt); end
      n_cmp++;
      if (done_cyc[0] !== 65 || done_cyc[1] !== 131) begin
         n_err++; $display("FAIL pending_done_cycles: got %0d,%0d required 65,131", done_cyc[0], done_cyc[1]);
      end
      n_cmp++;
      if (rd_cnt !== 64 || rd_cyc[32] !== 67 || rd_addr[32] !== 0) begin
         n_err++; $display("FAIL pending_second_start: got %0d reads, read32 at %0d addr %0d required 64, 67, 0", rd_cnt, rd_cyc[32], rd_addr[32]);
      end
      n_cmp++;
      if (get_bar(17) !== 10'd17 || busy !== 1'b0) begin
         n_err++; $display("FAIL pending_result: got bar17 %0d busy %b required 17/0", get_bar(17), busy);
      end
   endtask

   task automatic test_reset_mid();
      start_frame();
      repeat (29) @(negedge frame_clk);
      n_cmp++;
      if (get_bar(31) !== 10'd31 || busy !== 1'b1) begin
         n_err++; $display("FAIL midreset_pre: got bar31 %0d busy %b required 31/1", get_bar(31), busy);
      end
      Reset = 1'b1;
      #1;
      n_cmp++;
      if (bar_height !== '0 || busy !== 1'b0 || bin_rd !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL midreset_immediate: got heights %h busy %b rd %b done %b required all 0", bar_height, busy, bin_rd, done);
      end
      n_cmp++;
      if (max_idx !== '0 || max_height !== '0) begin
         n_err++; $display("FAIL midreset_max: got %0d/%0d required 0/0", max_idx, max_height);
      end
      repeat (2) @(negedge frame_clk);
      Reset = 1'b0;
      repeat (80) @(negedge frame_clk);
      n_cmp++;
      if (done_cnt !== 0) begin n_err++; $display("FAIL midreset_no_done: got %0d pulses required 0", done_cnt); end
      n_cmp++;
      if (bar_height !== '0 || busy !== 1'b0) begin
         n_err++; $display("FAIL midreset_after: got heights %h busy %b required 0/0", bar_height, busy);
      end
   endtask

   initial begin
      Reset     = 1'b1;
      frame_req = 1'b0;
      for (int i = 0; i < BC; i++) mag[i] = '0;
      test_reset();
      test_ramp();
      test_decay();
      test_ties();
      test_stall();
      test_pending();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
